// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//
// Lets N_MASTERS bus masters share one slave port. Commands are arbitrated
// round-robin and forwarded one at a time. The master ID of every accepted
// read goes into an in-order FIFO, so each DVA response is routed back to the
// master that issued the read. Writes are posted and expect no response.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   m_mcmd          per-master MCmd (3 bits each, IDLE/WR/RD)
//   m_maddr         per-master MAddr
//   m_mdata         per-master MData
//   m_mbyteen       per-master MByteEn
//   m_scmdaccept    per-master SCmdAccept (only the granted master sees it)
//   m_sresp         per-master SResp (2 bits each, NULL/DVA)
//   m_sdata         SData, broadcast to all masters
//   s_mcmd, s_maddr, s_mdata, s_mbyteen   command forwarded to the slave
//   s_mrespaccept   MRespAccept to the slave, always 1
//   s_scmdaccept    slave SCmdAccept
//   s_sresp, s_sdata  slave response
//   resp_err        sticky: a DVA arrived with no read outstanding
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3*N_MASTERS-1:0]            m_mcmd,
  input  logic [ADDR_WIDTH*N_MASTERS-1:0]   m_maddr,
  input  logic [DATA_WIDTH*N_MASTERS-1:0]   m_mdata,
  input  logic [(DATA_WIDTH/8)*N_MASTERS-1:0] m_mbyteen,
  output logic [N_MASTERS-1:0]              m_scmdaccept,
  output logic [2*N_MASTERS-1:0]            m_sresp,
  output logic [DATA_WIDTH-1:0]             m_sdata,
  output logic [2:0]                        s_mcmd,
  output logic [ADDR_WIDTH-1:0]             s_maddr,
  output logic [DATA_WIDTH-1:0]             s_mdata,
  output logic [DATA_WIDTH/8-1:0]           s_mbyteen,
  output logic                              s_mrespaccept,
  input  logic                              s_scmdaccept,
  input  logic [1:0]                        s_sresp,
  input  logic [DATA_WIDTH-1:0]             s_sdata,
  output logic                              resp_err
);

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_RD    = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int ID_WIDTH  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic [N_MASTERS-1:0] req;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic                 lock;
  logic [ID_WIDTH-1:0]  lock_id;
  logic                 gnt_valid;
  logic [ID_WIDTH-1:0]  gnt_id;
  logic [ID_WIDTH-1:0]  cand;
  int                   cand_i;

  logic [ID_WIDTH-1:0]  id_mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [ID_WIDTH-1:0]  head_id;

  function automatic logic [PTR_WIDTH-1:0] fifo_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) req[i] = (m_mcmd[3*i +: 3] != CMD_IDLE);
  end

  // Full is judged on the registered count, so a pop in the same cycle
  // does not release the stall until the next cycle.
  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = id_mem[rd_ptr];

  // Grant: a locked master keeps the bus until its command is accepted;
  // otherwise pick the first requester at or after rr_ptr, cyclically.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    cand_i    = 0;
    if (!reset && !full) begin
      if (lock) begin
        gnt_valid = 1'b1;
        gnt_id    = lock_id;
      end else begin
        for (int k = 0; k < N_MASTERS; k++) begin
          cand_i = int'(rr_ptr) + k;
          if (cand_i >= N_MASTERS) cand_i = cand_i - N_MASTERS;
          cand = ID_WIDTH'(cand_i);
          if (!gnt_valid && req[cand]) begin
            gnt_valid = 1'b1;
            gnt_id    = cand;
          end
        end
      end
    end
  end

  // Command forwarding and per-master accept.
  always_comb begin
    s_mcmd       = CMD_IDLE;
    s_maddr      = '0;
    s_mdata      = '0;
    s_mbyteen    = '0;
    m_scmdaccept = '0;
    if (gnt_valid) begin
      s_mcmd               = m_mcmd[3*gnt_id +: 3];
      s_maddr              = m_maddr[ADDR_WIDTH*gnt_id +: ADDR_WIDTH];
      s_mdata              = m_mdata[DATA_WIDTH*gnt_id +: DATA_WIDTH];
      s_mbyteen            = m_mbyteen[BE_WIDTH*gnt_id +: BE_WIDTH];
      m_scmdaccept[gnt_id] = s_scmdaccept;
    end
  end

  assign accept = (s_mcmd != CMD_IDLE) && s_scmdaccept;
  assign push   = accept && (s_mcmd == CMD_RD);
  assign pop    = (s_sresp == RESP_DVA) && !empty;

  // Response routing: only the FIFO head sees DVA; stray DVAs are dropped.
  always_comb begin
    m_sresp = {N_MASTERS{RESP_NULL}};
    if (pop) m_sresp[2*head_id +: 2] = RESP_DVA;
  end

  assign m_sdata       = s_sdata;
  assign s_mrespaccept = 1'b1;

  // NOTE: the ID storage has no reset; only the pointers and count define
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= gnt_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples values from before the edge, regardless of statement order.
    if (reset) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_id  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (gnt_valid && (s_mcmd != CMD_IDLE)) begin
        if (s_scmdaccept) begin
          lock   <= 1'b0;
          rr_ptr <= (gnt_id == ID_WIDTH'(N_MASTERS - 1)) ? '0 : gnt_id + 1'b1;
        end else begin
          lock    <= 1'b1;
          lock_id <= gnt_id;
        end
      end
      if (push) wr_ptr <= fifo_inc(wr_ptr);
      if (pop)  rd_ptr <= fifo_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((s_sresp == RESP_DVA) && empty) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
//
// Two-master, depth-4 bench. A table of per-cycle vectors walks the basic
// single-read, write-then-read, lock and stray-DVA cases. Hand-written
// sequences cover the full stall, reset mid-stall and back-to-back
// round-robin streaming, where expected response IDs are kept in a queue.
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [1:0] NUL  = 2'd0;
  localparam logic [1:0] DVA  = 2'd1;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] D0 = 32'hD0D0_0000;
  localparam logic [31:0] D1 = 32'hD1D1_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cmd0, cmd1;
  logic        sacc;
  logic [1:0]  sresp;
  logic [31:0] sdata;

  logic [5:0]  m_mcmd;
  logic [63:0] m_maddr;
  logic [63:0] m_mdata;
  logic [7:0]  m_mbyteen;
  logic [1:0]  m_scmdaccept;
  logic [3:0]  m_sresp;
  logic [31:0] m_sdata;
  logic [2:0]  s_mcmd;
  logic [31:0] s_maddr;
  logic [31:0] s_mdata;
  logic [3:0]  s_mbyteen;
  logic        s_mrespaccept;
  logic        resp_err;

  assign m_mcmd    = {cmd1, cmd0};
  assign m_maddr   = {A1, A0};
  assign m_mdata   = {D1, D0};
  assign m_mbyteen = {4'hC, 4'h3};

  always #5 clk = ~clk;

  bus_rr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .m_mcmd       (m_mcmd),
    .m_maddr      (m_maddr),
    .m_mdata      (m_mdata),
    .m_mbyteen    (m_mbyteen),
    .m_scmdaccept (m_scmdaccept),
    .m_sresp      (m_sresp),
    .m_sdata      (m_sdata),
    .s_mcmd       (s_mcmd),
    .s_maddr      (s_maddr),
    .s_mdata      (s_mdata),
    .s_mbyteen    (s_mbyteen),
    .s_mrespaccept(s_mrespaccept),
    .s_scmdaccept (sacc),
    .s_sresp      (sresp),
    .s_sdata      (sdata),
    .resp_err     (resp_err)
  );

  typedef struct {
    logic [2:0]  cmd0;
    logic [2:0]  cmd1;
    logic        sacc;
    logic [1:0]  sresp;
    logic [31:0] sdata;
    logic [2:0]  e_scmd;
    logic [31:0] e_addr;
    logic [1:0]  e_acc;
    logic [3:0]  e_mresp;
    logic        e_err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c0, input logic [2:0] c1, input logic a,
                       input logic [1:0] r, input logic [31:0] d);
    cmd0  = c0;
    cmd1  = c1;
    sacc  = a;
    sresp = r;
    sdata = d;
  endtask

  // Apply one cycle's inputs just after the rising edge; outputs are
  // then sampled on the following falling edge.
  task automatic next_cycle(input logic [2:0] c0, input logic [2:0] c1, input logic a,
                            input logic [1:0] r, input logic [31:0] d);
    @(posedge clk);
    #1;
    drive(c0, c1, a, r, d);
    @(negedge clk);
  endtask

  function automatic logic [3:0] dva_for(input int id);
    return 4'b0001 << (2 * id);
  endfunction

  vec_t vecs[13];

  initial begin
    logic [31:0] e_data;
    int          model_ptr;
    int          id;

    // cmd0 cmd1 sacc sresp sdata | scmd addr acc mresp err
    vecs[0]  = '{RD,   IDLE, 1'b1, NUL, 32'h0,         RD,   A0,    2'b01, 4'b0000, 1'b0};
    vecs[1]  = '{IDLE, IDLE, 1'b1, DVA, 32'hCAFE_0001, IDLE, 32'h0, 2'b00, 4'b0001, 1'b0};
    vecs[2]  = '{WR,   IDLE, 1'b1, NUL, 32'h0,         WR,   A0,    2'b01, 4'b0000, 1'b0};
    vecs[3]  = '{IDLE, RD,   1'b1, NUL, 32'h0,         RD,   A1,    2'b10, 4'b0000, 1'b0};
    vecs[4]  = '{IDLE, IDLE, 1'b1, DVA, 32'h1234_5678, IDLE, 32'h0, 2'b00, 4'b0100, 1'b0};
    vecs[5]  = '{IDLE, RD,   1'b0, NUL, 32'h0,         RD,   A1,    2'b00, 4'b0000, 1'b0};
    vecs[6]  = '{RD,   RD,   1'b0, NUL, 32'h0,         RD,   A1,    2'b00, 4'b0000, 1'b0};
    vecs[7]  = '{RD,   RD,   1'b0, NUL, 32'h0,         RD,   A1,    2'b00, 4'b0000, 1'b0};
    vecs[8]  = '{RD,   RD,   1'b1, NUL, 32'h0,         RD,   A1,    2'b10, 4'b0000, 1'b0};
    vecs[9]  = '{RD,   IDLE, 1'b1, DVA, 32'h5555_0009, RD,   A0,    2'b01, 4'b0100, 1'b0};
    vecs[10] = '{IDLE, IDLE, 1'b1, DVA, 32'h5555_000A, IDLE, 32'h0, 2'b00, 4'b0001, 1'b0};
    vecs[11] = '{IDLE, IDLE, 1'b1, DVA, 32'h5555_000B, IDLE, 32'h0, 2'b00, 4'b0000, 1'b0};
    vecs[12] = '{IDLE, IDLE, 1'b1, NUL, 32'h0,         IDLE, 32'h0, 2'b00, 4'b0000, 1'b1};

    // Reset with a live request: nothing may be forwarded.
    reset = 1'b1;
    drive(RD, IDLE, 1'b1, NUL, 32'h0);
    #2;
    check("rst s_mcmd", 64'(s_mcmd), 64'(IDLE));
    check("rst m_scmdaccept", 64'(m_scmdaccept), 64'h0);
    check("rst m_sresp", 64'(m_sresp), 64'h0);
    check("rst s_mrespaccept", 64'(s_mrespaccept), 64'h1);
    check("rst resp_err", 64'(resp_err), 64'h0);
    drive(IDLE, IDLE, 1'b0, NUL, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven cycles.
    for (int i = 0; i < 13; i++) begin
      next_cycle(vecs[i].cmd0, vecs[i].cmd1, vecs[i].sacc, vecs[i].sresp, vecs[i].sdata);
      e_data = (vecs[i].e_addr == A0) ? D0 : (vecs[i].e_addr == A1) ? D1 : 32'h0;
      check($sformatf("v%0d s_mcmd", i), 64'(s_mcmd), 64'(vecs[i].e_scmd));
      check($sformatf("v%0d s_maddr", i), 64'(s_maddr), 64'(vecs[i].e_addr));
      check($sformatf("v%0d s_mdata", i), 64'(s_mdata), 64'(e_data));
      check($sformatf("v%0d m_scmdaccept", i), 64'(m_scmdaccept), 64'(vecs[i].e_acc));
      check($sformatf("v%0d m_sresp", i), 64'(m_sresp), 64'(vecs[i].e_mresp));
      check($sformatf("v%0d m_sdata", i), 64'(m_sdata), 64'(vecs[i].sdata));
      check($sformatf("v%0d resp_err", i), 64'(resp_err), 64'(vecs[i].e_err));
    end

    // Fill the FIFO with four master-1 reads.
    for (int k = 0; k < 4; k++) begin
      next_cycle(IDLE, RD, 1'b1, NUL, 32'h0);
      check($sformatf("fill%0d s_mcmd", k), 64'(s_mcmd), 64'(RD));
      check($sformatf("fill%0d acc", k), 64'(m_scmdaccept), 64'b10);
      check($sformatf("fill%0d s_mbyteen", k), 64'(s_mbyteen), 64'hC);
      exp_q.push_back(1);
    end
    // Fifth request stalls.
    next_cycle(IDLE, RD, 1'b1, NUL, 32'h0);
    check("full s_mcmd", 64'(s_mcmd), 64'(IDLE));
    check("full acc", 64'(m_scmdaccept), 64'b00);
    check("full resp_err sticky", 64'(resp_err), 64'h1);
    // A pop while full still stalls this cycle.
    next_cycle(IDLE, RD, 1'b1, DVA, 32'hAAAA_0001);
    check("full+pop s_mcmd", 64'(s_mcmd), 64'(IDLE));
    check("full+pop acc", 64'(m_scmdaccept), 64'b00);
    id = exp_q.pop_front();
    check("full+pop m_sresp", 64'(m_sresp), 64'(dva_for(id)));
    // Released the cycle after the pop.
    next_cycle(IDLE, RD, 1'b1, NUL, 32'h0);
    check("release s_mcmd", 64'(s_mcmd), 64'(RD));
    check("release acc", 64'(m_scmdaccept), 64'b10);
    exp_q.push_back(1);
    next_cycle(IDLE, RD, 1'b1, NUL, 32'h0);
    check("refull s_mcmd", 64'(s_mcmd), 64'(IDLE));

    // Asynchronous reset in the middle of the stall.
    #2;
    reset = 1'b1;
    #1;
    check("midrst resp_err", 64'(resp_err), 64'h0);
    check("midrst s_mcmd", 64'(s_mcmd), 64'(IDLE));
    check("midrst acc", 64'(m_scmdaccept), 64'b00);
    check("midrst m_sresp", 64'(m_sresp), 64'h0);
    exp_q.delete();
    drive(IDLE, IDLE, 1'b0, NUL, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Both masters stream reads; grants must alternate starting from 0,
    // each DVA one cycle after acceptance, routed in issue order.
    model_ptr = 0;
    for (int k = 0; k < 8; k++) begin
      next_cycle(RD, RD, 1'b1, (k > 0) ? DVA : NUL, 32'hBEEF_0000 + 32'(k));
      check($sformatf("rr%0d acc", k), 64'(m_scmdaccept), 64'(2'b01 << model_ptr));
      check($sformatf("rr%0d s_maddr", k), 64'(s_maddr), 64'((model_ptr == 0) ? A0 : A1));
      if (k > 0) begin
        id = exp_q.pop_front();
        check($sformatf("rr%0d m_sresp", k), 64'(m_sresp), 64'(dva_for(id)));
        check($sformatf("rr%0d m_sdata", k), 64'(m_sdata), 64'(32'hBEEF_0000 + 32'(k)));
      end
      exp_q.push_back(model_ptr);
      model_ptr = 1 - model_ptr;
    end
    next_cycle(IDLE, IDLE, 1'b1, DVA, 32'hBEEF_0008);
    id = exp_q.pop_front();
    check("rr drain m_sresp", 64'(m_sresp), 64'(dva_for(id)));
    check("rr drain resp_err", 64'(resp_err), 64'h0);
    // FIFO should now be empty: another DVA is a stray.
    next_cycle(IDLE, IDLE, 1'b1, DVA, 32'hBEEF_0009);
    check("stray m_sresp", 64'(m_sresp), 64'h0);
    next_cycle(IDLE, IDLE, 1'b1, NUL, 32'h0);
    check("stray resp_err", 64'(resp_err), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shares one bus slave port between N_MASTERS bus masters, e.g. instruction-fetch and data RAM-to-bus bridges.
- Uses round-robin command arbitration and forwards exactly one master's command per accepted transfer.
- Records the granted master ID of every accepted read in an in-order FIFO, so each DVA response is routed back to the master that issued it.
- Sits between the master-side bridges and the bus interconnect or slave.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, MAddr width.
- DATA_WIDTH, 32, MData/SData width; MByteEn width is DATA_WIDTH/8.
- DEPTH, 4, maximum outstanding reads, i.e. response-ID FIFO depth (power of 2, ≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m_mcmd  in  3*N_MASTERS  per-master MCmd (Bus::IDLE/WR/RD encoding).
- m_maddr  in  ADDR_WIDTH*N_MASTERS  per-master MAddr.
- m_mdata  in  DATA_WIDTH*N_MASTERS  per-master MData.
- m_mbyteen  in  (DATA_WIDTH/8)*N_MASTERS  per-master MByteEn.
- m_scmdaccept  out  N_MASTERS  per-master SCmdAccept.
- m_sresp  out  2*N_MASTERS  per-master SResp (Bus::DVA or Bus::NULL).
- m_sdata  out  DATA_WIDTH  SData, broadcast to all masters.
- s_mcmd  out  3  MCmd to slave.
- s_maddr  out  ADDR_WIDTH  MAddr to slave.
- s_mdata  out  DATA_WIDTH  MData to slave.
- s_mbyteen  out  DATA_WIDTH/8  MByteEn to slave.
- s_mrespaccept  out  1  MRespAccept to slave, constant 1.
- s_scmdaccept  in  1  slave SCmdAccept.
- s_sresp  in  2  slave SResp.
- s_sdata  in  DATA_WIDTH  slave SData.
- resp_err  out  1  sticky flag: DVA received with no read outstanding.

Behaviour:
- Request: master i requests when its m_mcmd != IDLE.
- Grant is combinational. If a grant is locked, the locked master is granted. Otherwise the first requester at or after rr_ptr (cyclic) is granted. No requester means no grant.
- Lock: set when the granted command is not accepted in a cycle (s_scmdaccept=0 while s_mcmd!=IDLE); cleared on acceptance. The granted master holds its command stable until accepted, so the grant must not change mid-command.
- Forwarding: s_mcmd/s_maddr/s_mdata/s_mbyteen equal the granted master's fields. With no grant, s_mcmd=IDLE and the other slave-side fields are 0.
- m_scmdaccept[g] = s_scmdaccept for the granted master only; all other masters see 0.
- Acceptance (s_mcmd!=IDLE && s_scmdaccept): rr_ptr <= (g+1) mod N_MASTERS. If the command is RD, push g into the FIFO. WR is posted: nothing is pushed and no response is expected.
- Full stall: when FIFO count == DEPTH, no grant is issued. s_mcmd=IDLE, all m_scmdaccept=0, rr_ptr is unchanged. The stall applies even if a pop occurs in the same cycle (decided on registered count). Writes are blocked while full too.
- Response: when s_sresp==DVA and the FIFO is non-empty, m_sresp[head]=DVA and the FIFO pops. All other m_sresp are NULL. m_sdata = s_sdata always.
- Minimum read latency is 1 cycle: a DVA may arrive the cycle after acceptance. A response in the same cycle as acceptance of the read it answers is illegal.
- Push and pop in the same cycle: count is unchanged and the data order is preserved.
- DVA with empty FIFO: the response is dropped, all m_sresp are NULL, resp_err is set to 1 and holds until reset.
- Reset (asynchronous, may occur mid-transfer): rr_ptr=0, lock=0, FIFO empty (count=0), resp_err=0. The in-flight command is abandoned.
- Outputs during and after reset, until new requests arrive: s_mcmd=IDLE, all m_scmdaccept=0, all m_sresp=NULL, s_mrespaccept=1.
- Widths: count is clog2(DEPTH)+1 bits. FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH.

Test Plan:
- Single master 0 issues RD addr 0x100; slave accepts immediately and returns DVA data 0xCAFE0001 next cycle -> m_scmdaccept[0]=1, then m_sresp[0]=DVA, m_sdata=0xCAFE0001, m_sresp[1]=NULL.
- Masters 0 and 1 both request RD continuously, slave always accepts -> grants alternate 0,1,0,1; rr_ptr toggles each cycle; responses route 0,1,0,1 in order.
- Master 1 RD with s_scmdaccept held 0 for 3 cycles while master 0 starts requesting -> s_mcmd/s_maddr stay on master 1 for all 4 cycles; master 0 is granted only after master 1 is accepted.
- 4 RDs accepted with no responses (DEPTH=4) -> 5th request stalls (s_mcmd=IDLE, m_scmdaccept=0). One DVA -> stall is released the next cycle.
- WR from master 0 followed by RD from master 1 -> FIFO holds only ID 1; the single DVA goes to m_sresp[1].
- DVA while FIFO is empty -> no m_sresp asserted, resp_err=1 until reset. Asserting reset mid-stall -> count=0, rr_ptr=0, resp_err=0 immediately.
